operand_scoreboard: RTL

//  Operand-fetch and hazard unit for the decode stage of the RISC-V pipeline, with configurable forwarding.
//  It tracks in-flight register writes in per-register pending counters and selects each operand from
//  the youngest ready forwarding source, the register file or the immediate. It stalls issue when an

---
 rtl/operand_scoreboard_if.sv | 46 ++++
 rtl/operand_scoreboard.sv | 123 ++++++++++++
 2 files changed

// File: rtl/operand_scoreboard_if.sv
// Decode-stage operand/hazard bus: issue handshake, operand sources, forwarding,
// retire/squash notifications and the resolved operands.
interface operand_scoreboard_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NFWD = 2
);
  logic                 issue_valid;
  logic                 issue_ready;
  logic                 issue_we;
  logic [AW-1:0]        issue_waddr;
  logic                 re1;
  logic                 re2;
  logic [AW-1:0]        raddr1;
  logic [AW-1:0]        raddr2;
  logic [XLEN-1:0]      imm1;
  logic [XLEN-1:0]      imm2;
  logic [XLEN-1:0]      rf_data1;
  logic [XLEN-1:0]      rf_data2;
  logic [NFWD-1:0]      fwd_valid;
  logic [NFWD-1:0]      fwd_rdy;
  logic [NFWD*AW-1:0]   fwd_addr;
  logic [NFWD*XLEN-1:0] fwd_data;
  logic                 wb_valid;
  logic [AW-1:0]        wb_addr;
  logic                 sq_valid;
  logic [AW-1:0]        sq_addr;
  logic [XLEN-1:0]      opv1;
  logic [XLEN-1:0]      opv2;
  logic                 stall;
  logic [31:0]          stall_cnt;

  modport master (
    output issue_valid, issue_we, issue_waddr, re1, re2, raddr1, raddr2,
           imm1, imm2, rf_data1, rf_data2, fwd_valid, fwd_rdy, fwd_addr,
           fwd_data, wb_valid, wb_addr, sq_valid, sq_addr,
    input  issue_ready, opv1, opv2, stall, stall_cnt
  );

  modport slave (
    input  issue_valid, issue_we, issue_waddr, re1, re2, raddr1, raddr2,
           imm1, imm2, rf_data1, rf_data2, fwd_valid, fwd_rdy, fwd_addr,
           fwd_data, wb_valid, wb_addr, sq_valid, sq_addr,
    output issue_ready, opv1, opv2, stall, stall_cnt
  );
endinterface

// File: rtl/operand_scoreboard.sv
// Decode-stage operand fetch and hazard unit: per-register pending counters,
// youngest-first forwarding, and issue stall when an operand is not yet available.
module operand_scoreboard #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int NFWD   = 2,
  parameter int PEND_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  operand_scoreboard_if.slave  bus
);

  localparam int NREG = 2**AW;

  typedef logic [PEND_W-1:0] pend_t;

  pend_t           pend     [NREG];
  pend_t           pend_nxt [NREG];
  logic [31:0]     stall_cnt_q;

  logic            re       [2];
  logic [AW-1:0]   raddr    [2];
  logic [XLEN-1:0] imm      [2];
  logic [XLEN-1:0] rf_data  [2];
  logic [XLEN-1:0] op_val   [2];
  logic            op_stall [2];

  logic            sat;
  logic            ready;
  logic            stall;
  logic            inc_hit;

  assign re[0]      = bus.re1;
  assign re[1]      = bus.re2;
  assign raddr[0]   = bus.raddr1;
  assign raddr[1]   = bus.raddr2;
  assign imm[0]     = bus.imm1;
  assign imm[1]     = bus.imm2;
  assign rf_data[0] = bus.rf_data1;
  assign rf_data[1] = bus.rf_data2;

  // Operand resolution: youngest matching forward source, then pending check, then RF.
  always_comb begin
    logic            hit;
    logic            hit_rdy;
    logic [XLEN-1:0] hit_data;
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    hit      = 1'b0;
    hit_rdy  = 1'b0;
    hit_data = '0;
    for (int k = 0; k < 2; k++) begin
      op_val[k]   = '0;
      op_stall[k] = 1'b0;
      hit         = 1'b0;
      hit_rdy     = 1'b0;
      hit_data    = '0;
      if (!re[k]) begin
        op_val[k] = imm[k];
      end else if (raddr[k] != '0) begin
        // Scan oldest to youngest so the lowest matching index wins.
        for (int i = NFWD - 1; i >= 0; i--) begin
          if (bus.fwd_valid[i] && (bus.fwd_addr[i*AW +: AW] == raddr[k])) begin
            hit      = 1'b1;
            hit_rdy  = bus.fwd_rdy[i];
            hit_data = bus.fwd_data[i*XLEN +: XLEN];
          end
        end
        if (hit) begin
          if (hit_rdy) op_val[k]   = hit_data;
          else         op_stall[k] = 1'b1;
        end else if (pend[raddr[k]] != '0) begin
          op_stall[k] = 1'b1;
        end else begin
          op_val[k] = rf_data[k];
        end
      end
      if (rst || op_stall[k]) op_val[k] = '0;
    end
  end

  // Saturation looks only at the registered count; same-cycle decrements do not relieve it.
  assign sat     = bus.issue_we && (bus.issue_waddr != '0) && (pend[bus.issue_waddr] == '1);
  assign ready   = !rst && !op_stall[0] && !op_stall[1] && !sat;
  assign stall   = !rst && bus.issue_valid && !ready;
  assign inc_hit = bus.issue_valid && ready && bus.issue_we && (bus.issue_waddr != '0);

  // Net per-register change; an underflow clamps at zero and x0 is never pending.
  always_comb begin
    int cnt;
    cnt = 0;
    for (int r = 0; r < NREG; r++) begin
      cnt = int'(pend[r]);
      if (inc_hit      && (bus.issue_waddr == AW'(r))) cnt = cnt + 1;
      if (bus.wb_valid && (bus.wb_addr     == AW'(r))) cnt = cnt - 1;
      if (bus.sq_valid && (bus.sq_addr     == AW'(r))) cnt = cnt - 1;
      if (cnt < 0 || r == 0) cnt = 0;
      pend_nxt[r] = pend_t'(cnt);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the counter array is hazard state, not storage, so every entry is
      // reset; a stale nonzero count would stall forever.
      for (int r = 0; r < NREG; r++) pend[r] <= '0;
      stall_cnt_q <= '0;
    end else begin
      pend <= pend_nxt;
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.issue_ready = ready;
  assign bus.stall       = stall;
  assign bus.opv1        = op_val[0];
  assign bus.opv2        = op_val[1];
  assign bus.stall_cnt   = stall_cnt_q;

endmodule
